// File: rtl/side_ch_pkg.sv
// Shared definitions for the side-channel PS-to-PL receive path.
package side_ch_pkg;

  // Number of bits needed to hold the value itself (so 8192 -> 14).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

`ifdef SIDE_CH_LESS_BRAM
  localparam int unsigned MAX_NUM_DMA_SYMBOL_DEF = 4096;
`else
  localparam int unsigned MAX_NUM_DMA_SYMBOL_DEF = 8192;
`endif

  localparam int unsigned C_S_AXIS_TDATA_WIDTH_DEF = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/side_ch_sync_fifo.sv
// Single-clock FIFO with registered read port and registered count/flags.
module side_ch_sync_fifo
  import side_ch_pkg::*;
#(
  parameter int unsigned DATA_W = C_S_AXIS_TDATA_WIDTH_DEF,
  parameter int unsigned DEPTH  = MAX_NUM_DMA_SYMBOL_DEF,
  parameter int unsigned CNT_W  = clogb2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = CNT_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_ok_c;
  logic              rd_ok_c;

  assign wr_ok_c = wr_en & ~full_q;
  assign rd_ok_c = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_ok_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_ok_c, rd_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_ok_c) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/side_ch_ps2pl_rx.sv
// AXI-Stream slave buffering PS DMA words for PL consumption, with frame
// end detection by beat count or tlast and frame-length error pulses.
module side_ch_ps2pl_rx
  import side_ch_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH   = C_S_AXIS_TDATA_WIDTH_DEF,
  parameter int unsigned MAX_NUM_DMA_SYMBOL     = MAX_NUM_DMA_SYMBOL_DEF,
  parameter int unsigned MAX_BIT_NUM_DMA_SYMBOL = clogb2(MAX_NUM_DMA_SYMBOL)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_axis_endless_mode,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   num_dma_symbol_m1,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  output logic                                s_axis_state,
  input  logic                                pl_ask_data,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     data_to_pl,
  output logic                                data_to_pl_valid,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   s_axis_data_count,
  output logic                                emptyn_to_pl,
  output logic                                frame_done,
  output logic                                frame_short,
  output logic                                frame_long
);

  localparam int unsigned CW = MAX_BIT_NUM_DMA_SYMBOL;

  rx_state_e   state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_short_q, frame_short_d;
  logic        frame_long_q, frame_long_d;
  logic        data_to_pl_valid_q, data_to_pl_valid_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          tready_c;
  logic          accept_c;
  logic          cnt_hit_c;
  logic          frame_end_c;
  logic          pop_c;
  logic          unused_tstrb_c;

  assign unused_tstrb_c = ^S_AXIS_TSTRB;

  // Ready follows state and occupancy only, never TVALID.
  assign tready_c    = (state_q == S_RECV) & ~fifo_full;
  assign accept_c    = S_AXIS_TVALID & tready_c;
  assign cnt_hit_c   = ~s_axis_endless_mode & (beat_cnt_q == num_dma_symbol_m1);
  assign frame_end_c = accept_c & (S_AXIS_TLAST | cnt_hit_c);
  assign pop_c       = pl_ask_data & emptyn_to_pl;

  always_comb begin
    state_d            = state_q;
    beat_cnt_d         = beat_cnt_q;
    frame_done_d       = frame_end_c;
    frame_short_d      = accept_c & ~s_axis_endless_mode & S_AXIS_TLAST &
                         (beat_cnt_q < num_dma_symbol_m1);
    frame_long_d       = accept_c & cnt_hit_c & ~S_AXIS_TLAST;
    data_to_pl_valid_d = pop_c;
    unique case (state_q)
      S_IDLE: begin
        if (S_AXIS_TVALID) state_d = S_RECV;
      end
      S_RECV: begin
        if (frame_end_c) begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
        end else if (accept_c) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      beat_cnt_q         <= '0;
      frame_done_q       <= 1'b0;
      frame_short_q      <= 1'b0;
      frame_long_q       <= 1'b0;
      data_to_pl_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      beat_cnt_q         <= beat_cnt_d;
      frame_done_q       <= frame_done_d;
      frame_short_q      <= frame_short_d;
      frame_long_q       <= frame_long_d;
      data_to_pl_valid_q <= data_to_pl_valid_d;
    end
  end

  side_ch_sync_fifo #(
    .DATA_W (C_S_AXIS_TDATA_WIDTH),
    .DEPTH  (MAX_NUM_DMA_SYMBOL),
    .CNT_W  (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_c),
    .wr_data (S_AXIS_TDATA),
    .rd_en   (pop_c),
    .rd_data (data_to_pl),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign S_AXIS_TREADY     = tready_c;
  assign s_axis_state      = (state_q == S_RECV);
  assign data_to_pl_valid  = data_to_pl_valid_q;
  assign s_axis_data_count = fifo_count;
  assign emptyn_to_pl      = ~fifo_empty;
  assign frame_done        = frame_done_q;
  assign frame_short       = frame_short_q;
  assign frame_long        = frame_long_q;

endmodule

// File: tb/tb_side_ch_ps2pl_rx.sv
// Directed bench for side_ch_ps2pl_rx built with an 8-entry FIFO.
module tb_side_ch_ps2pl_rx;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk;
  logic          rst;
  logic          endless;
  logic [CW-1:0] m1;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tlast;
  logic          state;
  logic          ask;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic [CW-1:0] count;
  logic          emptyn;
  logic          fdone;
  logic          fshort;
  logic          flong;

  int tests = 0;
  int fails = 0;

  side_ch_ps2pl_rx #(
    .C_S_AXIS_TDATA_WIDTH   (DW),
    .MAX_NUM_DMA_SYMBOL     (DEPTH),
    .MAX_BIT_NUM_DMA_SYMBOL (CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_endless_mode (endless),
    .num_dma_symbol_m1   (m1),
    .S_AXIS_TVALID       (tvalid),
    .S_AXIS_TREADY       (tready),
    .S_AXIS_TDATA        (tdata),
    .S_AXIS_TSTRB        (tstrb),
    .S_AXIS_TLAST        (tlast),
    .s_axis_state        (state),
    .pl_ask_data         (ask),
    .data_to_pl          (dout),
    .data_to_pl_valid    (dvalid),
    .s_axis_data_count   (count),
    .emptyn_to_pl        (emptyn),
    .frame_done          (fdone),
    .frame_short         (fshort),
    .frame_long          (flong)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until the handshake edge has passed.
  task automatic send_beat(input logic [63:0] d, input logic l);
    bit done;
    done   = 1'b0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    for (int k = 0; k < 20 && !done; k++) begin
      if (tready) done = 1'b1;
      cyc();
    end
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL hs_timeout: got 0x%0h expected 0x1", done);
    end
    tlast = 1'b0;
  endtask

  task automatic pop_expect(input logic [63:0] exp, input logic [CW-1:0] exp_cnt);
    ask = 1'b1;
    cyc();
    ask = 1'b0;
    chk("pop_valid", 64'(dvalid), 64'h1);
    chk("pop_data", dout, exp);
    chk("pop_count", 64'(count), 64'(exp_cnt));
  endtask

  initial begin
    rst     = 1'b1;
    endless = 1'b0;
    m1      = '0;
    tvalid  = 1'b0;
    tdata   = '0;
    tstrb   = '1;
    tlast   = 1'b0;
    ask     = 1'b0;
    cyc();
    cyc();
    chk("rst_tready", 64'(tready), 64'h0);
    chk("rst_state", 64'(state), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_emptyn", 64'(emptyn), 64'h0);
    chk("rst_dout", dout, 64'h0);
    chk("rst_dvalid", 64'(dvalid), 64'h0);
    chk("rst_fdone", 64'(fdone), 64'h0);
    rst = 1'b0;

    // 4-beat frame, length matches tlast
    m1 = 4'd3;
    send_beat(64'h11, 1'b0);
    send_beat(64'h22, 1'b0);
    send_beat(64'h33, 1'b0);
    send_beat(64'h44, 1'b1);
    tvalid = 1'b0;
    chk("f1_done", 64'(fdone), 64'h1);
    chk("f1_short", 64'(fshort), 64'h0);
    chk("f1_long", 64'(flong), 64'h0);
    chk("f1_count", 64'(count), 64'h4);
    chk("f1_state", 64'(state), 64'h0);
    chk("f1_emptyn", 64'(emptyn), 64'h1);
    cyc();
    chk("f1_done_clr", 64'(fdone), 64'h0);

    // back-to-back pops, then a pop while empty
    pop_expect(64'h11, 4'd3);
    pop_expect(64'h22, 4'd2);
    pop_expect(64'h33, 4'd1);
    pop_expect(64'h44, 4'd0);
    chk("drain_emptyn", 64'(emptyn), 64'h0);
    ask = 1'b1;
    cyc();
    ask = 1'b0;
    chk("empty_pop_valid", 64'(dvalid), 64'h0);
    chk("empty_pop_count", 64'(count), 64'h0);
    chk("empty_pop_hold", dout, 64'h44);

    // short frame: tlast on beat 3 of 8
    m1 = 4'd7;
    send_beat(64'hA1, 1'b0);
    send_beat(64'hA2, 1'b0);
    send_beat(64'hA3, 1'b1);
    tvalid = 1'b0;
    chk("short_done", 64'(fdone), 64'h1);
    chk("short_flag", 64'(fshort), 64'h1);
    chk("short_long", 64'(flong), 64'h0);
    chk("short_state", 64'(state), 64'h0);
    pop_expect(64'hA1, 4'd2);
    pop_expect(64'hA2, 4'd1);
    pop_expect(64'hA3, 4'd0);

    // long frame: 8 beats without tlast
    for (int i = 0; i < 7; i++) send_beat(64'hB0 + 64'(i), 1'b0);
    chk("long_pre_state", 64'(state), 64'h1);
    chk("long_pre_done", 64'(fdone), 64'h0);
    chk("long_pre_flag", 64'(flong), 64'h0);
    send_beat(64'hB7, 1'b0);
    tvalid = 1'b0;
    chk("long_done", 64'(fdone), 64'h1);
    chk("long_flag", 64'(flong), 64'h1);
    chk("long_short", 64'(fshort), 64'h0);
    chk("long_state", 64'(state), 64'h0);
    chk("long_count", 64'(count), 64'h8);
    for (int i = 0; i < 8; i++) pop_expect(64'hB0 + 64'(i), CW'(7 - i));

    // full FIFO back-pressure in endless mode
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    endless = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(64'hC0 + 64'(i), 1'b0);
    chk("full_count", 64'(count), 64'h8);
    chk("full_tready", 64'(tready), 64'h0);
    tvalid = 1'b1;
    tdata  = 64'hC8;
    cyc();
    cyc();
    chk("full_hold_tready", 64'(tready), 64'h0);
    chk("full_hold_count", 64'(count), 64'h8);
    chk("full_state", 64'(state), 64'h1);
    ask = 1'b1;
    cyc();
    ask = 1'b0;
    chk("full_pop_data", dout, 64'hC0);
    chk("full_pop_count", 64'(count), 64'h7);
    chk("full_pop_tready", 64'(tready), 64'h1);
    cyc();
    tvalid = 1'b0;
    chk("refill_count", 64'(count), 64'h8);
    chk("refill_tready", 64'(tready), 64'h0);

    // reset in the middle of a frame
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    endless = 1'b0;
    m1 = 4'd7;
    for (int i = 0; i < 5; i++) send_beat(64'h50 + 64'(i), 1'b0);
    tvalid = 1'b0;
    chk("mid_count", 64'(count), 64'h5);
    rst = 1'b1;
    cyc();
    chk("midrst_count", 64'(count), 64'h0);
    chk("midrst_tready", 64'(tready), 64'h0);
    chk("midrst_state", 64'(state), 64'h0);
    chk("midrst_emptyn", 64'(emptyn), 64'h0);
    rst = 1'b0;
    m1 = 4'd3;
    send_beat(64'hD0, 1'b0);
    send_beat(64'hD1, 1'b0);
    send_beat(64'hD2, 1'b0);
    chk("post_rst_state", 64'(state), 64'h1);
    chk("post_rst_nodone", 64'(fdone), 64'h0);
    send_beat(64'hD3, 1'b0);
    tvalid = 1'b0;
    chk("post_rst_done", 64'(fdone), 64'h1);
    chk("post_rst_long", 64'(flong), 64'h1);
    chk("post_rst_short", 64'(fshort), 64'h0);
    chk("post_rst_count", 64'(count), 64'h4);

    // steady push+pop from occupancy 2
    pop_expect(64'hD0, 4'd3);
    pop_expect(64'hD1, 4'd2);
    endless = 1'b1;
    tvalid  = 1'b1;
    tdata   = 64'hE0;
    cyc();
    chk("stream_state", 64'(state), 64'h1);
    for (int i = 0; i < 6; i++) begin
      logic [63:0] exp;
      exp   = (i == 0) ? 64'hD2 : (i == 1) ? 64'hD3 : 64'hE0 + 64'(i - 2);
      tdata = 64'hE0 + 64'(i);
      chk("stream_tready", 64'(tready), 64'h1);
      ask = 1'b1;
      cyc();
      chk("stream_count", 64'(count), 64'h2);
      chk("stream_valid", 64'(dvalid), 64'h1);
      chk("stream_data", dout, exp);
    end
    tvalid = 1'b0;
    ask    = 1'b0;
    pop_expect(64'hE4, 4'd1);
    pop_expect(64'hE5, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/side_ch_ps2pl_rx.md
Name: side_ch_ps2pl_rx

Overview:
AXI-Stream slave that receives 64-bit words from the PS DMA (MM2S) into the side-channel PL domain. It is the PS-to-PL counterpart of the side-channel m_axis upload path. Words are buffered in an internal FIFO of MAX_NUM_DMA_SYMBOL entries, and PL logic pops them one at a time through a request/strobe port. Frame end is determined by either a programmable beat count or tlast, and frame-length errors are flagged.

Parameters:
C_S_AXIS_TDATA_WIDTH, 64, stream and FIFO word width
MAX_NUM_DMA_SYMBOL, 8192 (4096 when SIDE_CH_LESS_BRAM is defined), FIFO depth; must be a power of 2
MAX_BIT_NUM_DMA_SYMBOL, clogb2(MAX_NUM_DMA_SYMBOL) = 14, width of the count and length fields

Ports:
clk  in  1  single clock for the whole block
rst  in  1  synchronous reset, active-high
s_axis_endless_mode  in  1  1 = only tlast ends a frame
num_dma_symbol_m1  in  MAX_BIT_NUM_DMA_SYMBOL  frame length minus 1, in beats
S_AXIS_TVALID  in  1  stream valid
S_AXIS_TREADY  out  1  stream ready
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  ignored; all bytes are treated as valid
S_AXIS_TLAST  in  1  last beat of the DMA transfer
s_axis_state  out  1  0 = IDLE, 1 = RECV
pl_ask_data  in  1  pop request from PL logic
data_to_pl  out  C_S_AXIS_TDATA_WIDTH  popped word
data_to_pl_valid  out  1  one-cycle strobe qualifying data_to_pl
s_axis_data_count  out  MAX_BIT_NUM_DMA_SYMBOL  FIFO occupancy, 0..MAX_NUM_DMA_SYMBOL
emptyn_to_pl  out  1  FIFO not empty
frame_done  out  1  one-cycle pulse on the last accepted beat of a frame
frame_short  out  1  pulse: tlast arrived before the count target (non-endless mode)
frame_long  out  1  pulse: count target reached without tlast (non-endless mode)

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state IDLE;
  - FIFO pointers and count to 0;
  - beat counter to 0;
  - all outputs 0 (TREADY, data_to_pl, data_to_pl_valid, emptyn_to_pl, frame_* pulses).
- Reset mid-frame discards all buffered data. The PS must restart the DMA afterwards.
- Handshake: a beat is accepted on a cycle where TVALID & TREADY.
- TREADY = (state==RECV) & (count < MAX_NUM_DMA_SYMBOL).
  - TREADY is combinational from state and count; it never depends on TVALID.
  - When the FIFO is full, TREADY=0 and TVALID/TDATA are held by the master.
- FSM:
  - IDLE -> RECV on the cycle after TVALID is seen high. TREADY is 0 while in IDLE.
  - RECV -> IDLE on an accepted beat if either:
    - TLAST=1; or
    - s_axis_endless_mode=0 and beat_cnt==num_dma_symbol_m1.
  - The transition takes effect at the next edge, and beat_cnt clears to 0 at the same edge.
  - Otherwise, each accepted beat increments beat_cnt. In endless mode beat_cnt wraps modulo 2^MAX_BIT_NUM_DMA_SYMBOL.
  - num_dma_symbol_m1 is sampled on every beat; changing it mid-frame is the user's responsibility.
- frame_done pulses in the cycle after the last accepted beat of a frame.
- Frame-length errors (non-endless mode only); both pulse together with frame_done:
  - frame_short: TLAST=1 while beat_cnt < num_dma_symbol_m1.
  - frame_long: beat_cnt == num_dma_symbol_m1 with TLAST=0. Beats that follow start a new frame via IDLE.
- FIFO write: an accepted beat is written to the FIFO in the same cycle.
- FIFO read:
  - pl_ask_data while emptyn_to_pl=1 pops one word.
  - data_to_pl is registered and data_to_pl_valid=1 exactly 1 cycle later.
  - data_to_pl holds its value until the next pop.
  - pl_ask_data while empty is ignored: no count change and no valid strobe.
- Simultaneous push and pop: count unchanged and both pointers advance.
- A pop in the same cycle as the first write into an empty FIFO is ignored, because emptyn_to_pl is registered from count.
- s_axis_data_count and emptyn_to_pl are registered and updated at the edge following the push/pop.
- Pointers are MAX_BIT_NUM_DMA_SYMBOL-1 bits wide and wrap naturally. The count width allows the full value MAX_NUM_DMA_SYMBOL.
- Throughput: one write and one read per clock are sustained.

Decomposition:
- Shared package side_ch_pkg holds:
  - clogb2 function;
  - MAX_NUM_DMA_SYMBOL default and SIDE_CH_LESS_BRAM selection;
  - FSM state encoding constants S_IDLE=0 and S_RECV=1.
- One sub-module: side_ch_sync_fifo.
  - Single-clock, BRAM-inferable, registered-read FIFO.
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - The top module keeps the FSM, beat counter, error flags and handshake.

Test Plan:
1. Reset, endless=0, num_dma_symbol_m1=3; send 4 beats 0x11..0x44 with tlast on the 4th -> 4 accepted; frame_done=1; frame_short=0, frame_long=0; count=4; state returns to IDLE.
2. After scenario 1, assert pl_ask_data for 4 consecutive cycles -> data_to_pl_valid on 4 cycles, each 1 cycle after its request, data 0x11,0x22,0x33,0x44; count steps 3,2,1,0; emptyn_to_pl=0; a 5th request gives no strobe.
3. Depth 8 build, endless=1; stream 10 beats with no pops -> TREADY drops after 8 accepted; count=8; TDATA held; one pop -> next beat accepted and count stays 8.
4. endless=0, num_dma_symbol_m1=7; tlast on beat 3 -> frame_short and frame_done pulse; beat_cnt resets to 0. Repeat with 8 beats and no tlast -> frame_long pulse on beat 8.
5. Continuous push with a pop every cycle from a count of 2 -> count stays 2 and data order is preserved.
6. Assert rst mid-frame after 5 beats -> next cycle count=0, TREADY=0, state IDLE; the following frame is received correctly from beat 0.
